// File: rtl/puf_crp_engine.sv
// puf_crp_engine: UART-byte-protocol challenge/response sequencer for the XOR-PUF core.
// Parses 0x01/0x02 frames, drives chal_en/puf_start, returns status + response bytes.
module puf_crp_engine #(
  parameter int CLOCK_FRE      = 100000000,
  parameter int BAUD_RATE      = 9600,
  parameter int CHAL_BYTES     = 16,
  parameter int RESP_BYTES     = 16,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic                      en_16_x_baud,
  input  logic [7:0]                rx_data,
  input  logic                      rx_data_present,
  output logic                      rx_read,
  output logic [7:0]                tx_data,
  input  logic                      tx_full,
  output logic                      tx_write,
  output logic [CHAL_BYTES*8-1:0]   challenge,
  output logic                      chal_en,
  output logic                      puf_start,
  input  logic                      response_ready,
  input  logic [RESP_BYTES*8-1:0]   response,
  output logic                      busy
);
  localparam int P  = CLOCK_FRE / (BAUD_RATE * 16);
  localparam int BW = $clog2(P + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, GET_CNT, GET_CHAL, SETTLE, START, WAIT, SEND_STAT, SEND_RESP} state_t;

  state_t                  state_q, state_d;
  logic [CHAL_BYTES*8-1:0] chal_q, chal_d;
  logic [RESP_BYTES*8-1:0] resp_q, resp_d;
  logic                    chal_en_q, chal_en_d;
  logic [8:0]              rep_q, rep_d;
  logic [5:0]              idx_q, idx_d;
  logic [SW-1:0]           set_q, set_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic [7:0]              stat_q, stat_d;
  logic [BW-1:0]           baud_q;
  logic                    gap_q, take, send;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      chal_q    <= '0;
      resp_q    <= '0;
      chal_en_q <= 1'b0;
      rep_q     <= '0;
      idx_q     <= '0;
      set_q     <= '0;
      tmo_q     <= '0;
      stat_q    <= '0;
      baud_q    <= '0;
      gap_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      chal_q    <= chal_d;
      resp_q    <= resp_d;
      chal_en_q <= chal_en_d;
      rep_q     <= rep_d;
      idx_q     <= idx_d;
      set_q     <= set_d;
      tmo_q     <= tmo_d;
      stat_q    <= stat_d;
      baud_q    <= (baud_q == BW'(P - 1)) ? '0 : baud_q + 1'b1;
      gap_q     <= rx_read;
    end

  always_comb begin
    // gap_q blocks a second pop while the FIFO empty flag catches up
    take         = (state_q == IDLE || state_q == GET_CNT || state_q == GET_CHAL) && rx_data_present && !gap_q;
    send         = (state_q == SEND_STAT || state_q == SEND_RESP) && !tx_full;
    rx_read      = take;
    tx_write     = send;
    tx_data      = state_q == SEND_STAT ? stat_q : state_q == SEND_RESP ? resp_q[{idx_q, 3'b000} +: 8] : 8'h00;
    puf_start    = state_q == START;
    busy         = state_q != IDLE;
    chal_en      = chal_en_q;
    challenge    = chal_q;
    en_16_x_baud = baud_q == BW'(P - 1);
    state_d      = state_q;
    chal_d       = chal_q;
    resp_d       = resp_q;
    chal_en_d    = chal_en_q;
    rep_d        = rep_q;
    idx_d        = idx_q;
    set_d        = set_q;
    tmo_d        = tmo_q;
    stat_d       = stat_q;
    case (state_q)
      IDLE: if (take) begin
        idx_d = '0;
        if (rx_data == 8'h01) begin
          rep_d   = 9'd1;
          state_d = GET_CHAL;
        end else if (rx_data == 8'h02) state_d = GET_CNT;
        else begin
          stat_d  = 8'h3F;
          state_d = SEND_STAT;
        end
      end
      GET_CNT: if (take) begin
        rep_d   = rx_data == 8'h00 ? 9'd256 : {1'b0, rx_data};
        state_d = GET_CHAL;
      end
      GET_CHAL: if (take) begin
        chal_d[{idx_q, 3'b000} +: 8] = rx_data;
        idx_d = idx_q + 1'b1;
        if (idx_q == 6'(CHAL_BYTES - 1)) begin
          chal_en_d = 1'b1;
          set_d     = '0;
          tmo_d     = '0;
          state_d   = SETTLE;
        end
      end
      SETTLE: begin
        tmo_d = tmo_q + 1'b1;
        set_d = response_ready ? '0 : set_q + 1'b1;
        if (!response_ready && set_q == SW'(SETTLE_CYCLES - 1)) state_d = START;
        else if (response_ready && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          stat_d  = 8'hEE;
          state_d = SEND_STAT;
        end
      end
      START: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        tmo_d = tmo_q + 1'b1;
        if (response_ready) begin
          resp_d  = response;
          stat_d  = 8'hA5;
          state_d = SEND_STAT;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          stat_d  = 8'hEE;
          state_d = SEND_STAT;
        end
      end
      SEND_STAT: if (send) begin
        idx_d = '0;
        if (stat_q == 8'hA5) state_d = SEND_RESP;
        else begin
          chal_en_d = 1'b0;
          rep_d     = '0;
          state_d   = IDLE;
        end
      end
      SEND_RESP: if (send) begin
        idx_d = idx_q + 1'b1;
        if (idx_q == 6'(RESP_BYTES - 1)) begin
          idx_d = '0;
          rep_d = rep_q - 1'b1;
          if (rep_q > 9'd1) begin
            set_d   = '0;
            tmo_d   = '0;
            state_d = SETTLE;
          end else begin
            chal_en_d = 1'b0;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_puf_crp_engine.sv
// tb_puf_crp_engine: directed frames with a TX scoreboard, RX FIFO model and PUF model.
module tb_puf_crp_engine;
  localparam int CB = 16, RB = 16;
  logic clk = 1'b0, rst_n = 1'b0;
  logic en_16_x_baud, rx_read, tx_write, chal_en, puf_start, busy;
  logic [7:0] rx_data = 8'h00, tx_data;
  logic rx_data_present = 1'b0, tx_full = 1'b0, response_ready = 1'b0;
  logic [CB*8-1:0] challenge;
  logic [RB*8-1:0] response;
  int tests = 0, fails = 0;
  int reads = 0, starts = 0, txs = 0, sc = 0, puf_cnt = 0, rr_hold = 0;
  bit puf_en = 1'b1, rd_pend = 1'b0;
  byte unsigned rx_q[$], exp_q[$];

  always #5 clk = ~clk;

  puf_crp_engine #(.CLOCK_FRE(100000000), .BAUD_RATE(9600), .CHAL_BYTES(CB), .RESP_BYTES(RB),
                   .SETTLE_CYCLES(16), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n), .en_16_x_baud(en_16_x_baud), .rx_data(rx_data),
    .rx_data_present(rx_data_present), .rx_read(rx_read), .tx_data(tx_data), .tx_full(tx_full),
    .tx_write(tx_write), .challenge(challenge), .chal_en(chal_en), .puf_start(puf_start),
    .response_ready(response_ready), .response(response), .busy(busy));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // RX FIFO model: pops one cycle after the DUT consumed, flushed while in reset
  always @(negedge clk) begin
    if (!rst_n) begin
      rx_q.delete();
      rd_pend = 1'b0;
    end else if (rd_pend) begin
      void'(rx_q.pop_front());
      reads++;
    end
    rx_data_present = rx_q.size() > 0;
    rx_data = rx_q.size() > 0 ? rx_q[0] : 8'h00;
    #1 rd_pend = rx_read;
  end

  // TX scoreboard monitor and PUF response model
  always @(negedge clk) begin
    if (tx_write) begin
      txs++;
      if (tx_full) chk("tx_write_while_full", 32'd1, 32'd0);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL tx_unexpected: got %0h expected no byte", tx_data);
      end else chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
    end
    if (puf_start) begin
      starts++;
      chk("settle_before_start", sc >= 16, 1);
      if (puf_en) puf_cnt = 10;
    end
    sc = (chal_en && !response_ready) ? sc + 1 : 0;
    if (rr_hold > 0) rr_hold--;
    if (puf_cnt > 0) begin
      puf_cnt--;
      if (puf_cnt == 0) rr_hold = 2;
    end
    response_ready = rr_hold > 0;
  end

  task automatic push_frame(input byte unsigned cmd, input byte unsigned n, input byte unsigned base);
    rx_q.push_back(cmd);
    if (cmd == 8'h02) rx_q.push_back(n);
    for (int i = 0; i < CB; i++) rx_q.push_back(byte'(base + i));
  endtask

  task automatic exp_eval(input int times);
    for (int t = 0; t < times; t++) begin
      exp_q.push_back(8'hA5);
      for (int k = 0; k < RB; k++) exp_q.push_back(byte'(8'hF0 + k));
    end
  endtask

  task automatic wait_idle(input string name, input int maxc);
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(name, n < maxc, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, r0, t0, n, a, b;
    for (int k = 0; k < RB; k++) response[8*k +: 8] = 8'hF0 + 8'(k);
    repeat (3) @(negedge clk);
    chk("rst_challenge", |challenge, 0);
    chk("rst_chal_en", chal_en, 0);
    chk("rst_puf_start", puf_start, 0);
    chk("rst_rx_read", rx_read, 0);
    chk("rst_tx_write", tx_write, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_baud", en_16_x_baud, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk) #2 rst_n = 1'b1;

    s0 = starts;
    push_frame(8'h01, 8'h00, 8'h00);
    exp_eval(1);
    wait_idle("single_done", 2000);
    chk("single_chal_b0", challenge[7:0], 8'h00);
    chk("single_chal_b1", challenge[15:8], 8'h01);
    chk("single_chal_b15", challenge[127:120], 8'h0F);
    chk("single_starts", starts - s0, 1);
    chk("single_busy", busy, 0);
    chk("single_chal_en", chal_en, 0);

    s0 = starts;
    t0 = txs;
    push_frame(8'h02, 8'h03, 8'h20);
    exp_eval(3);
    wait_idle("repeat_done", 3000);
    chk("repeat_starts", starts - s0, 3);
    chk("repeat_tx_count", txs - t0, 51);
    chk("repeat_chal_b15", challenge[127:120], 8'h2F);

    r0 = reads;
    t0 = txs;
    rx_q.push_back(8'h7E);
    exp_q.push_back(8'h3F);
    wait_idle("badcmd_done", 200);
    chk("badcmd_reads", reads - r0, 1);
    chk("badcmd_tx_count", txs - t0, 1);
    chk("badcmd_busy", busy, 0);
    push_frame(8'h01, 8'h00, 8'h40);
    exp_eval(1);
    wait_idle("after_bad_done", 2000);
    chk("after_bad_chal_b15", challenge[127:120], 8'h4F);

    s0 = starts;
    t0 = txs;
    puf_en = 1'b0;
    push_frame(8'h02, 8'h05, 8'h50);
    exp_q.push_back(8'hEE);
    wait_idle("timeout_done", 2000);
    chk("timeout_starts", starts - s0, 1);
    chk("timeout_tx_count", txs - t0, 1);
    chk("timeout_chal_en", chal_en, 0);
    chk("timeout_busy", busy, 0);
    puf_en = 1'b1;

    t0 = txs;
    push_frame(8'h01, 8'h00, 8'h60);
    exp_eval(1);
    n = 0;
    while (txs - t0 < 5 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("txfull_reach_resp", n < 2000, 1);
    @(posedge clk) #2 tx_full = 1'b1;
    repeat (50) @(posedge clk);
    #2 tx_full = 1'b0;
    wait_idle("txfull_done", 2000);
    chk("txfull_tx_count", txs - t0, 17);

    r0 = reads;
    push_frame(8'h01, 8'h00, 8'h80);
    n = 0;
    while (reads - r0 < 8 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("midreset_reach_byte7", n < 2000, 1);
    @(posedge clk) #2 rst_n = 1'b0;
    #1;
    chk("midreset_challenge", |challenge, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_chal_en", chal_en, 0);
    chk("midreset_rx_read", rx_read, 0);
    chk("midreset_tx_write", tx_write, 0);
    chk("midreset_tx_data", tx_data, 0);
    repeat (2) @(negedge clk);
    @(posedge clk) #2 rst_n = 1'b1;
    s0 = starts;
    push_frame(8'h01, 8'h00, 8'h70);
    exp_eval(1);
    wait_idle("postreset_done", 2000);
    chk("postreset_chal_b0", challenge[7:0], 8'h70);
    chk("postreset_chal_b15", challenge[127:120], 8'h7F);
    chk("postreset_starts", starts - s0, 1);

    a = -1;
    b = -1;
    for (int c = 0; c < 1500 && b < 0; c++) begin
      @(negedge clk);
      if (en_16_x_baud) begin
        if (a < 0) a = c;
        else b = c;
      end
    end
    chk("baud_period", (a >= 0 && b >= 0) ? b - a : 0, 651);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/puf_crp_engine.md
Name: puf_crp_engine

Overview:
- Hardware challenge-response sequencer for the XOR-PUF test platform; replaces firmware-driven CRP collection with a fixed byte protocol.
- Sits between the uart_rx6/uart_tx6 FIFOs and the PUF core.
- Parses command frames from the RX FIFO, assembles a parametrised-width challenge, drives the challenge-enable and start strobes, and waits for response-ready with a timeout.
- Returns a status byte and the response bytes through the TX FIFO; supports single and repeated evaluation; generates the 16x baud enable.

Parameters:
CLOCK_FRE, 100000000, system clock frequency in Hz
BAUD_RATE, 9600, UART baud rate
CHAL_BYTES, 16, challenge width in bytes (1..32)
RESP_BYTES, 16, response width in bytes (1..32)
SETTLE_CYCLES, 16, cycles chal_en is held before puf_start (>=1)
TIMEOUT_CYCLES, 1000000, maximum cycles from puf_start to response_ready

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
en_16_x_baud  out  1  one-cycle pulse every CLOCK_FRE/(BAUD_RATE*16) cycles
rx_data  in  8  RX FIFO head byte, valid while rx_data_present=1
rx_data_present  in  1  RX FIFO non-empty
rx_read  out  1  one-cycle pop of RX FIFO
tx_data  out  8  byte to TX FIFO
tx_full  in  1  TX FIFO full
tx_write  out  1  one-cycle push to TX FIFO
challenge  out  CHAL_BYTES*8  applied challenge; byte k = bits [8k+7:8k]
chal_en  out  1  challenge-enable to PUF
puf_start  out  1  PUF start strobe
response_ready  in  1  PUF response valid
response  in  RESP_BYTES*8  PUF response; byte k = bits [8k+7:8k]
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst_n=0, async): state IDLE; outputs challenge=0, chal_en=0, puf_start=0, rx_read=0, tx_write=0, tx_data=0, en_16_x_baud=0, busy=0. Baud counter, repeat counter, timeout counter and response latch all cleared. Reset mid-frame discards the partial frame; already-pushed TX bytes are not recalled.
- Baud generator: counter runs 0..P-1, where P=CLOCK_FRE/(BAUD_RATE*16). en_16_x_baud=1 in the cycle the counter equals P-1, giving exactly one pulse per P cycles.
- RX consume rule: a byte is consumed when rx_data_present=1 in a byte-accepting state. rx_data is sampled in that cycle and rx_read pulses that same cycle. The following cycle is a mandatory gap in which no byte is consumed (FIFO flag update).
- TX rule: in a sending state, if tx_full=0, drive tx_data and pulse tx_write for one cycle, then advance. If tx_full=1, hold with tx_write=0.
- Frame formats:
  - 0x01 followed by CHAL_BYTES bytes, LSB byte first: single evaluation.
  - 0x02 followed by count N (0 means 256), then CHAL_BYTES bytes: N evaluations of the same challenge.
  - Any other first byte: consumed, status 0x3F sent, return to IDLE.
- States:
  - IDLE: consume command byte. 0x01 sets rep=1 and goes to GET_CHAL; 0x02 goes to GET_CNT; other values go to SEND_STAT with 0x3F.
  - GET_CNT: consume N and set rep=N (N=0 loads 256).
  - GET_CHAL: byte index i writes challenge[8i+7:8i]. After the last byte, go to SETTLE. chal_en is asserted on entry to SETTLE.
  - SETTLE: wait for response_ready=0, then count SETTLE_CYCLES, then go to START. Timeout counter runs from SETTLE entry.
  - START: puf_start=1 for exactly one cycle; timeout counter reloads; go to WAIT.
  - WAIT: in the first cycle with response_ready=1, latch response and go to SEND_STAT with 0xA5. If the counter reaches TIMEOUT_CYCLES first, go to SEND_STAT with 0xEE.
  - SEND_STAT: send the status byte. 0xA5 goes to SEND_RESP; 0xEE and 0x3F clear chal_en and rep, then go to IDLE (remaining repeats aborted).
  - SEND_RESP: send the latched response bytes 0..RESP_BYTES-1, LSB first. Then decrement rep: if rep>0, go to SETTLE (chal_en stays high, challenge unchanged); else clear chal_en and go to IDLE.
- response_ready rising in the same cycle as timeout expiry: response wins (0xA5).
- RX bytes that arrive while not in IDLE, GET_CNT or GET_CHAL remain in the FIFO; there is no flush.
- challenge holds its last value after a frame completes; it changes only while bytes are being received in GET_CHAL.

Test Plan:
- Reset then 0x01 followed by 16 bytes 0x00..0x0F; PUF model asserts response_ready 10 cycles after puf_start with response bytes 0xF0..0xFF -> challenge byte0=0x00, byte15=0x0F; exactly one puf_start pulse; TX stream 0xA5, 0xF0..0xFF; then busy=0 and chal_en=0.
- 0x02, 0x03, challenge -> three puf_start pulses, each preceded by >=SETTLE_CYCLES of chal_en=1 with response_ready=0; TX carries 3x(1+16)=51 bytes.
- Command 0x7E -> exactly one rx_read, TX stream 0x3F only, back in IDLE; a following 0x01 frame completes normally.
- Timeout with TIMEOUT_CYCLES=100 and response_ready never asserted inside an 0x02/0x05 frame -> TX stream 0xEE only, one puf_start, chal_en=0, IDLE.
- tx_full held high for 50 cycles during SEND_RESP -> no tx_write while full, no byte lost or duplicated.
- rst_n pulsed low during GET_CHAL at byte 7 -> all outputs zero immediately; next full frame evaluates correctly. With P=651, en_16_x_baud period is exactly 651 cycles.
